// File: rtl/lc4_div_pkg.sv
// Shared types and sizing for the LC4 iterative divide/modulo sequencer.
package lc4_div_pkg;
  localparam int DATA_W = 16;
  localparam int TAG_W  = 3;
  localparam int CNT_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // RUN cycles needed to resolve all quotient bits.
  function automatic logic [CNT_W-1:0] iter_count(input int bits_per_cycle);
    return CNT_W'(DATA_W / bits_per_cycle);
  endfunction
endpackage

// File: rtl/lc4_div_step.sv
// One combinational restoring-division step on a {rem, quo} register pair.
module lc4_div_step
  import lc4_div_pkg::*;
(
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] quo_i,
  input  logic [DATA_W-1:0] div_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] quo_o
);
  logic [DATA_W:0]   shifted;
  logic [DATA_W-1:0] diff;

  assign shifted = {rem_i, quo_i[DATA_W-1]};
  // When the subtract happens the true difference is below the divisor, so 16 bits hold it.
  assign diff    = shifted[DATA_W-1:0] - div_i;

  always_comb begin
    if (shifted >= {1'b0, div_i}) begin
      rem_o = diff;
      quo_o = {quo_i[DATA_W-2:0], 1'b1};
    end else begin
      rem_o = shifted[DATA_W-1:0];
      quo_o = {quo_i[DATA_W-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/lc4_div_seq.sv
// Multi-cycle unsigned DIV/MOD sequencer with valid/ready request and response ports.
// Handshakes: a transfer happens on a rising edge where valid & ready are both high; valid never depends on ready.
module lc4_div_seq
  import lc4_div_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_op_mod,
  input  logic [DATA_W-1:0] i_dividend,
  input  logic [DATA_W-1:0] i_divisor,
  input  logic [TAG_W-1:0]  i_rd,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [DATA_W-1:0] o_result,
  output logic [TAG_W-1:0]  o_resp_rd,
  output logic              o_busy,
  output logic [1:0]        o_dbg_state
);
  localparam logic [CNT_W-1:0] N_ITER = iter_count(BITS_PER_CYCLE);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              op_q;
  logic [TAG_W-1:0]  rd_q;
  logic [DATA_W-1:0] div_q;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] result_q;

  logic [DATA_W-1:0] rem_c [BITS_PER_CYCLE+1];
  logic [DATA_W-1:0] quo_c [BITS_PER_CYCLE+1];

  assign rem_c[0] = rem_q;
  assign quo_c[0] = quo_q;

  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    lc4_div_step u_step (
      .rem_i (rem_c[g]),
      .quo_i (quo_c[g]),
      .div_i (div_q),
      .rem_o (rem_c[g+1]),
      .quo_o (quo_c[g+1])
    );
  end

  assign o_req_ready  = (state_q == IDLE) & ~i_flush;
  assign o_resp_valid = (state_q == DONE);
  assign o_busy       = (state_q != IDLE);
  assign o_result     = result_q;
  assign o_resp_rd    = rd_q;
  assign o_dbg_state  = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= 1'b0;
      rd_q     <= '0;
      div_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
    end else if (i_flush) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_req_valid) begin
            op_q  <= i_op_mod;
            rd_q  <= i_rd;
            div_q <= i_divisor;
            if (i_divisor == '0) begin
              // LC4 defines both x/0 and x%0 as zero.
              result_q <= '0;
              state_q  <= DONE;
            end else begin
              rem_q   <= '0;
              quo_q   <= i_dividend;
              cnt_q   <= N_ITER;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          rem_q <= rem_c[BITS_PER_CYCLE];
          quo_q <= quo_c[BITS_PER_CYCLE];
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            result_q <= op_q ? rem_c[BITS_PER_CYCLE] : quo_c[BITS_PER_CYCLE];
            state_q  <= DONE;
          end
        end
        DONE: begin
          if (i_resp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lc4_div_seq.sv
// Bench for lc4_div_seq: one-bit and four-bit-per-cycle instances share stimulus, each has its own scoreboard.
module tb_lc4_div_seq;
  logic clk;
  logic rst_n;
  logic flush, req_valid, op_mod, resp_ready;
  logic [15:0] dividend, divisor;
  logic [2:0]  rd;

  logic        rr1, v1, busy1, rr4, v4, busy4;
  logic [15:0] r1, r4;
  logic [2:0]  rd1, rd4;
  logic [1:0]  st1, st4;

  lc4_div_seq #(.BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_req_valid(req_valid), .o_req_ready(rr1),
    .i_op_mod(op_mod), .i_dividend(dividend), .i_divisor(divisor), .i_rd(rd),
    .o_resp_valid(v1), .i_resp_ready(resp_ready), .o_result(r1), .o_resp_rd(rd1),
    .o_busy(busy1), .o_dbg_state(st1)
  );

  lc4_div_seq #(.BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_req_valid(req_valid), .o_req_ready(rr4),
    .i_op_mod(op_mod), .i_dividend(dividend), .i_divisor(divisor), .i_rd(rd),
    .o_resp_valid(v4), .i_resp_ready(resp_ready), .o_result(r4), .o_resp_rd(rd4),
    .o_busy(busy4), .o_dbg_state(st4)
  );

  // ---------------- clock / reset / bookkeeping ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int acc_cyc  = 0;
  bit mon_en4  = 1'b1;
  bit seen1    = 1'b0;
  bit seen4    = 1'b0;

  // Entry: {latency[23:19], tag[18:16], result[15:0]}
  logic [23:0] exp_q1[$];
  logic [23:0] exp_q4[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic timeout_fail(input string name);
    chk_cnt++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (!rst_n) seen1 = 1'b0;
    else begin
      if (v1) begin
        if (exp_q1.size() == 0) begin
          if (!seen1) begin
            chk_cnt++;
            $display("FAIL dut1_unexpected_resp: got result %0h tag %0h, required none", r1, rd1);
          end
        end else begin
          if (!seen1) chk("dut1_latency", cyc - acc_cyc, 32'(exp_q1[0][23:19]));
          chk("dut1_result", r1, exp_q1[0][15:0]);
          chk("dut1_tag", rd1, exp_q1[0][18:16]);
          if (resp_ready) void'(exp_q1.pop_front());
        end
      end
      seen1 = v1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n || !mon_en4) seen4 = 1'b0;
    else begin
      if (v4) begin
        if (exp_q4.size() == 0) begin
          if (!seen4) begin
            chk_cnt++;
            $display("FAIL dut4_unexpected_resp: got result %0h tag %0h, required none", r4, rd4);
          end
        end else begin
          if (!seen4) chk("dut4_latency", cyc - acc_cyc, 32'(exp_q4[0][23:19]));
          chk("dut4_result", r4, exp_q4[0][15:0]);
          chk("dut4_tag", rd4, exp_q4[0][18:16]);
          if (resp_ready) void'(exp_q4.pop_front());
        end
      end
      seen4 = v4;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic mod, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] tag, input logic [15:0] exp_r,
                       input bit push1, input bit push4);
    int n = 0;
    @(negedge clk);
    while (!(rr1 && rr4) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!(rr1 && rr4)) begin
      timeout_fail("issue_wait_ready");
      return;
    end
    op_mod    = mod;
    dividend  = a;
    divisor   = b;
    rd        = tag;
    req_valid = 1'b1;
    if (push1) exp_q1.push_back({(b == 16'h0) ? 5'd0 : 5'd16, tag, exp_r});
    if (push4) exp_q4.push_back({(b == 16'h0) ? 5'd0 : 5'd4, tag, exp_r});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    acc_cyc   = cyc;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q1.size() != 0 || exp_q4.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q1.size() != 0 || exp_q4.size() != 0) timeout_fail("drain");
  endtask

  function automatic logic [15:0] ref_div(input logic mod, input logic [15:0] a, input logic [15:0] b);
    if (b == 16'h0) return 16'h0;
    return mod ? (a % b) : (a / b);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [15:0] a, b;
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; op_mod = 1'b0;
    dividend = '0; divisor = '0; rd = '0; resp_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready1", rr1, 1);
    chk("rst_req_ready4", rr4, 1);
    chk("rst_resp_valid1", v1, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_busy4", busy4, 0);
    chk("rst_result1", r1, 0);
    chk("rst_tag1", rd1, 0);
    chk("rst_state1", st1, 0);

    // basic divide and modulo
    issue(1'b0, 16'd100, 16'd7, 3'd5, 16'd14, 1, 1);
    issue(1'b1, 16'd100, 16'd7, 3'd5, 16'd2, 1, 1);
    drain();

    // divide by zero
    issue(1'b0, 16'h1234, 16'h0, 3'd1, 16'h0000, 1, 1);
    issue(1'b1, 16'h1234, 16'h0, 3'd6, 16'h0000, 1, 1);
    drain();

    // backpressure
    resp_ready = 1'b0;
    issue(1'b0, 16'hFFFF, 16'h0001, 3'd3, 16'hFFFF, 1, 1);
    n = 0;
    while (!v1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!v1) timeout_fail("bp_wait_valid");
    repeat (5) begin
      chk("bp_req_ready1", rr1, 0);
      chk("bp_req_ready4", rr4, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_ready_after1", rr1, 1);
    chk("bp_ready_after4", rr4, 1);
    drain();

    // flush on RUN cycle 8 of the one-bit instance
    mon_en4    = 1'b0;
    resp_ready = 1'b0;
    issue(1'b0, 16'h8000, 16'h0003, 3'd4, 16'h2AAA, 0, 0);
    repeat (7) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_state1", st1, 0);
    chk("flush_valid1", v1, 0);
    chk("flush_busy1", busy1, 0);
    chk("flush_valid4", v4, 0);
    chk("flush_busy4", busy4, 0);
    repeat (20) @(negedge clk);
    mon_en4    = 1'b1;
    resp_ready = 1'b1;
    issue(1'b0, 16'h8000, 16'h0003, 3'd4, 16'h2AAA, 1, 1);
    issue(1'b1, 16'h8000, 16'h0003, 3'd4, 16'h0002, 1, 1);
    drain();

    // asynchronous reset on RUN cycle 5
    mon_en4 = 1'b0;
    issue(1'b0, 16'd100, 16'd7, 3'd5, 16'd14, 0, 0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy1", busy1, 0);
    chk("arst_valid1", v1, 0);
    chk("arst_busy4", busy4, 0);
    chk("arst_valid4", v4, 0);
    chk("arst_result1", r1, 0);
    chk("arst_tag1", rd1, 0);
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    mon_en4 = 1'b1;
    repeat (25) @(negedge clk);
    chk("arst_idle_after1", busy1, 0);
    chk("arst_idle_after4", busy4, 0);

    // wide-step vectors, then random operands against the reference
    issue(1'b0, 16'hFFFE, 16'h00FF, 3'd7, 16'h0100, 1, 1);
    issue(1'b1, 16'hFFFE, 16'h00FF, 3'd2, 16'h00FE, 1, 1);
    for (int i = 0; i < 12; i++) begin
      a = 16'($urandom_range(0, 65535));
      if (i % 4 == 0)      b = 16'h0;
      else if (i % 4 == 1) b = 16'($urandom_range(1, 300));
      else                 b = 16'($urandom_range(1, 65535));
      issue(i[0], a, b, 3'(i), ref_div(i[0], a, b), 1, 1);
    end
    drain();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, chk_cnt);
    $fatal(1);
  end
endmodule
